// File: rtl/triad_encoder_pkg.sv
// Shared definitions for the distrip triad encoder: channel state encoding,
// triad length and the half-strip to triad-bit mapping.
package triad_encoder_pkg;

  localparam int unsigned TRIAD_LEN   = 3;
  localparam int unsigned HS_PER_CHAN = 4;

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0,
    TX_B0   = 3'd1,
    TX_B1   = 3'd2,
    TX_B2   = 3'd3,
    TX_DEAD = 3'd4
  } tx_state_e;

  // Triad for half-strip k, MSB first in time: start bit, strip, half-strip.
  function automatic logic [TRIAD_LEN-1:0] hs_to_triad(input logic [1:0] k);
    return {1'b1, k};
  endfunction

  // Index of the lowest set bit of a nibble (0 for an empty nibble).
  function automatic logic [1:0] lowest_hs(input logic [HS_PER_CHAN-1:0] nib);
    logic [1:0] k;
    k = 2'd0;
    if (nib[0])      k = 2'd0;
    else if (nib[1]) k = 2'd1;
    else if (nib[2]) k = 2'd2;
    else if (nib[3]) k = 2'd3;
    return k;
  endfunction

  // True when more than one half-strip bit is set.
  function automatic logic multi_hot(input logic [HS_PER_CHAN-1:0] nib);
    return (nib & (nib - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/triad_encoder_chan.sv
// One distrip channel: serialises a latched half-strip as a 3-bit triad,
// then holds the line low for the latched dead-time.
module triad_tx_chan
  import triad_encoder_pkg::*;
#(
  parameter int unsigned DEADW = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   accept,
  input  logic [HS_PER_CHAN-1:0] nibble,
  input  logic [DEADW-1:0]       dead_time,
  input  logic                   cnt_clr,
  output logic                   idle,
  output logic                   distrip,
  output logic                   multihit,
  output logic                   done
);

  tx_state_e              state_q, state_d;
  logic [TRIAD_LEN-1:0]   triad_q, triad_d;
  logic [DEADW-1:0]       dead_q, dead_d;
  logic [DEADW-1:0]       cnt_q, cnt_d;
  logic                   distrip_q, distrip_d;
  logic                   multihit_q, multihit_d;

  // Next-state, latched triad/dead-time, registered output bit and sticky flag.
  always_comb begin
    state_d    = state_q;
    triad_d    = triad_q;
    dead_d     = dead_q;
    cnt_d      = cnt_q;
    distrip_d  = 1'b0;
    multihit_d = multihit_q;

    case (state_q)
      TX_IDLE: begin
        if (accept && (nibble != '0)) begin
          state_d = TX_B0;
          triad_d = hs_to_triad(lowest_hs(nibble));
          dead_d  = dead_time;
        end
      end
      TX_B0: state_d = TX_B1;
      TX_B1: state_d = TX_B2;
      TX_B2: begin
        if (dead_q == '0) begin
          state_d = TX_IDLE;
        end else begin
          state_d = TX_DEAD;
          cnt_d   = dead_q - DEADW'(1);
        end
      end
      TX_DEAD: begin
        if (cnt_q == '0) state_d = TX_IDLE;
        else             cnt_d   = cnt_q - DEADW'(1);
      end
      default: state_d = TX_IDLE;
    endcase

    // Output bit is registered from the next state so it lines up with the state.
    case (state_d)
      TX_B0:   distrip_d = triad_d[TRIAD_LEN-1];
      TX_B1:   distrip_d = triad_d[TRIAD_LEN-2];
      TX_B2:   distrip_d = triad_d[TRIAD_LEN-3];
      default: distrip_d = 1'b0;
    endcase

    if (cnt_clr)
      multihit_d = 1'b0;
    else if (accept && multi_hot(nibble))
      multihit_d = 1'b1;
  end

  // Channel state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= TX_IDLE;
      triad_q    <= '0;
      dead_q     <= '0;
      cnt_q      <= '0;
      distrip_q  <= 1'b0;
      multihit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      triad_q    <= triad_d;
      dead_q     <= dead_d;
      cnt_q      <= cnt_d;
      distrip_q  <= distrip_d;
      multihit_q <= multihit_d;
    end
  end

  assign idle     = (state_q == TX_IDLE);
  assign done     = (state_q == TX_B2);
  assign distrip  = distrip_q;
  assign multihit = multihit_q;

endmodule

// File: rtl/triad_encoder.sv
// Distrip triad encoder: NCHAN parallel triad transmitters sharing one load
// strobe, plus transmitted/overrun counters.
module triad_encoder
  import triad_encoder_pkg::*;
#(
  parameter int unsigned NCHAN = 8,
  parameter int unsigned DEADW = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [HS_PER_CHAN*NCHAN-1:0] hs_req,
  input  logic                         load,
  input  logic [DEADW-1:0]             dead_time,
  output logic                         ready,
  output logic [NCHAN-1:0]             distrip,
  output logic [NCHAN-1:0]             multihit,
  output logic [15:0]                  overrun_cnt,
  output logic [15:0]                  sent_cnt,
  input  logic                         cnt_clr
);

  logic [NCHAN-1:0] idle;
  logic [NCHAN-1:0] done;
  logic             accept;
  logic [15:0]      overrun_cnt_q, overrun_cnt_d;
  logic [15:0]      sent_cnt_q, sent_cnt_d;
  logic [15:0]      n_done;

  assign ready  = &idle;
  assign accept = load & ready;

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    triad_tx_chan #(.DEADW(DEADW)) u_chan (
      .clock     (clock),
      .reset     (reset),
      .accept    (accept),
      .nibble    (hs_req[HS_PER_CHAN*i +: HS_PER_CHAN]),
      .dead_time (dead_time),
      .cnt_clr   (cnt_clr),
      .idle      (idle[i]),
      .distrip   (distrip[i]),
      .multihit  (multihit[i]),
      .done      (done[i])
    );
  end

  // Counter updates: completions summed per cycle, dropped loads saturate.
  always_comb begin
    n_done = '0;
    for (int unsigned i = 0; i < NCHAN; i++)
      n_done = n_done + 16'(done[i]);

    sent_cnt_d    = sent_cnt_q + n_done;
    overrun_cnt_d = overrun_cnt_q;
    if (load && !ready && (overrun_cnt_q != '1))
      overrun_cnt_d = overrun_cnt_q + 16'd1;

    if (cnt_clr) begin
      sent_cnt_d    = '0;
      overrun_cnt_d = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sent_cnt_q    <= '0;
      overrun_cnt_q <= '0;
    end else begin
      sent_cnt_q    <= sent_cnt_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign sent_cnt    = sent_cnt_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_triad_encoder.sv
// Directed self-checking bench for triad_encoder.
module tb_triad_encoder;

  logic        clock;
  logic        reset;
  logic [31:0] hs_req;
  logic        load;
  logic [3:0]  dead_time;
  logic        ready;
  logic [7:0]  distrip;
  logic [7:0]  multihit;
  logic [15:0] overrun_cnt;
  logic [15:0] sent_cnt;
  logic        cnt_clr;

  int checks = 0;
  int errors = 0;

  triad_encoder #(.NCHAN(8), .DEADW(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .hs_req      (hs_req),
    .load        (load),
    .dead_time   (dead_time),
    .ready       (ready),
    .distrip     (distrip),
    .multihit    (multihit),
    .overrun_cnt (overrun_cnt),
    .sent_cnt    (sent_cnt),
    .cnt_clr     (cnt_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; load = 1'b0; cnt_clr = 1'b0; hs_req = '0; dead_time = '0;
    repeat (3) tick;
    reset = 1'b1;
    tick;
    checks++;
    if (distrip !== 8'h00) begin errors++; $display("FAIL reset_distrip got %h exp 00", distrip); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++;
    if ({multihit, overrun_cnt, sent_cnt} !== 40'h0) begin
      errors++; $display("FAIL reset_counters got mh=%h ov=%0d sent=%0d exp 0", multihit, overrun_cnt, sent_cnt);
    end
  endtask

  // ch0 k=3 -> 111, dead 2: ready back at N+6.
  task automatic test_single;
    logic [7:0] exp_d [1:3];
    exp_d[1] = 8'h01; exp_d[2] = 8'h01; exp_d[3] = 8'h01;
    hs_req = 32'h0000_0008; dead_time = 4'd2; load = 1'b1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL single_ready_N got %b exp 1", ready); end
    for (int c = 1; c <= 3; c++) begin
      tick;
      load = 1'b0; hs_req = '0;
      checks++;
      if (distrip !== exp_d[c]) begin errors++; $display("FAIL single_bit%0d got %h exp %h", c, distrip, exp_d[c]); end
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL single_busy%0d got %b exp 0", c, ready); end
    end
    checks++;
    if (sent_cnt !== 16'd0) begin errors++; $display("FAIL single_sent_early got %0d exp 0", sent_cnt); end
    tick; // N+4
    checks++;
    if (distrip !== 8'h00 || ready !== 1'b0 || sent_cnt !== 16'd1) begin
      errors++; $display("FAIL single_N4 got d=%h r=%b s=%0d exp d=00 r=0 s=1", distrip, ready, sent_cnt);
    end
    tick; // N+5
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL single_dead_N5 got %b exp 0", ready); end
    tick; // N+6
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL single_ready_N6 got %b exp 1", ready); end
  endtask

  // ch5 k=0 (100), ch6 k=1 (101), ch7 nibble 3 -> lowest k=0 (100) + multihit.
  task automatic test_parallel;
    logic [7:0] exp_d [1:3];
    exp_d[1] = 8'hE0; exp_d[2] = 8'h00; exp_d[3] = 8'h40;
    hs_req = 32'h3210_0000; dead_time = 4'd0; load = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick;
      load = 1'b0; hs_req = 32'hFFFF_FFFF; dead_time = 4'd9;
      checks++;
      if (distrip !== exp_d[c]) begin errors++; $display("FAIL parallel_bit%0d got %h exp %h", c, distrip, exp_d[c]); end
    end
    checks++;
    if (multihit !== 8'h80) begin errors++; $display("FAIL parallel_multihit got %h exp 80", multihit); end
    checks++;
    if (sent_cnt !== 16'd1) begin errors++; $display("FAIL parallel_sent_N3 got %0d exp 1", sent_cnt); end
    tick; // N+4
    checks++;
    if (ready !== 1'b1 || sent_cnt !== 16'd4 || distrip !== 8'h00) begin
      errors++; $display("FAIL parallel_N4 got r=%b s=%0d d=%h exp r=1 s=4 d=00", ready, sent_cnt, distrip);
    end
  endtask

  // ch2 nibble 6 -> k=1 (101), multihit[2] sticky until cnt_clr.
  task automatic test_multihit;
    logic [7:0] exp_d [1:3];
    exp_d[1] = 8'h04; exp_d[2] = 8'h00; exp_d[3] = 8'h04;
    hs_req = 32'h0000_0600; dead_time = 4'd0; load = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick;
      load = 1'b0; hs_req = '0;
      checks++;
      if (distrip !== exp_d[c]) begin errors++; $display("FAIL multihit_bit%0d got %h exp %h", c, distrip, exp_d[c]); end
    end
    tick; tick;
    checks++;
    if (multihit !== 8'h84 || sent_cnt !== 16'd5) begin
      errors++; $display("FAIL multihit_held got mh=%h s=%0d exp mh=84 s=5", multihit, sent_cnt);
    end
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    checks++;
    if (multihit !== 8'h00 || sent_cnt !== 16'd0) begin
      errors++; $display("FAIL multihit_clr got mh=%h s=%0d exp mh=00 s=0", multihit, sent_cnt);
    end
  endtask

  task automatic test_zero_load;
    hs_req = '0; dead_time = 4'd3; load = 1'b1;
    tick;
    load = 1'b0;
    checks++;
    if (ready !== 1'b1 || distrip !== 8'h00 || sent_cnt !== 16'd0 || overrun_cnt !== 16'd0) begin
      errors++; $display("FAIL zero_load got r=%b d=%h s=%0d ov=%0d exp r=1 d=00 s=0 ov=0",
                         ready, distrip, sent_cnt, overrun_cnt);
    end
  endtask

  // ch0 k=0 (100), dead 1; two dropped loads; cnt_clr on the completion cycle.
  task automatic test_overrun;
    hs_req = 32'h0000_0001; dead_time = 4'd1; load = 1'b1;
    tick; // N+1
    hs_req = 32'h0000_0008; dead_time = 4'd7; load = 1'b1;
    checks++;
    if (distrip !== 8'h01) begin errors++; $display("FAIL overrun_b0 got %h exp 01", distrip); end
    tick; // N+2
    load = 1'b1;
    checks++;
    if (distrip !== 8'h00 || overrun_cnt !== 16'd1) begin
      errors++; $display("FAIL overrun_N2 got d=%h ov=%0d exp d=00 ov=1", distrip, overrun_cnt);
    end
    tick; // N+3
    load = 1'b0;
    checks++;
    if (distrip !== 8'h00 || overrun_cnt !== 16'd2 || ready !== 1'b0) begin
      errors++; $display("FAIL overrun_N3 got d=%h ov=%0d r=%b exp d=00 ov=2 r=0", distrip, overrun_cnt, ready);
    end
    cnt_clr = 1'b1;
    tick; // N+4
    cnt_clr = 1'b0;
    checks++;
    if (sent_cnt !== 16'd0 || overrun_cnt !== 16'd0 || ready !== 1'b0) begin
      errors++; $display("FAIL overrun_clr got s=%0d ov=%0d r=%b exp s=0 ov=0 r=0", sent_cnt, overrun_cnt, ready);
    end
    tick; // N+5
    checks++;
    if (ready !== 1'b1 || sent_cnt !== 16'd0) begin
      errors++; $display("FAIL overrun_N5 got r=%b s=%0d exp r=1 s=0", ready, sent_cnt);
    end
    hs_req = '0;
  endtask

  // ch1 nibble C -> k=2 (110); reset asserted while b1=1 is on the line.
  task automatic test_reset_mid;
    logic [7:0] exp_d [1:3];
    hs_req = 32'h0000_00C0; dead_time = 4'd0; load = 1'b1;
    tick; // N+1
    hs_req = '0; load = 1'b1;
    checks++;
    if (distrip !== 8'h02 || multihit !== 8'h02) begin
      errors++; $display("FAIL rstmid_N1 got d=%h mh=%h exp d=02 mh=02", distrip, multihit);
    end
    tick; // N+2
    load = 1'b0;
    checks++;
    if (distrip !== 8'h02 || overrun_cnt !== 16'd1) begin
      errors++; $display("FAIL rstmid_N2 got d=%h ov=%0d exp d=02 ov=1", distrip, overrun_cnt);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (distrip !== 8'h00 || multihit !== 8'h00 || overrun_cnt !== 16'd0 || sent_cnt !== 16'd0) begin
      errors++; $display("FAIL rstmid_async got d=%h mh=%h ov=%0d s=%0d exp all 0",
                         distrip, multihit, overrun_cnt, sent_cnt);
    end
    tick; tick;
    reset = 1'b1;
    tick;
    checks++;
    if (ready !== 1'b1 || sent_cnt !== 16'd0) begin
      errors++; $display("FAIL rstmid_release got r=%b s=%0d exp r=1 s=0", ready, sent_cnt);
    end
    exp_d[1] = 8'h01; exp_d[2] = 8'h01; exp_d[3] = 8'h00;
    hs_req = 32'h0000_0004; load = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick;
      load = 1'b0; hs_req = '0;
      checks++;
      if (distrip !== exp_d[c]) begin errors++; $display("FAIL rstmid_next_bit%0d got %h exp %h", c, distrip, exp_d[c]); end
    end
    tick;
    checks++;
    if (sent_cnt !== 16'd1 || ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_next_done got s=%0d r=%b exp s=1 r=1", sent_cnt, ready);
    end
  endtask

  // Loads issued the first cycle ready returns; decode each triad back to k.
  task automatic test_back_to_back;
    logic [31:0] req;
    logic [15:0] exp_k, got_k;
    logic [7:0]  b0, b1, b2;
    logic [3:0]  nib;
    int          w;
    logic        timed_out;
    timed_out = 1'b0;
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    dead_time = 4'd5;
    for (int it = 0; it < 100 && !timed_out; it++) begin
      w = 0;
      while (!ready && w < 20) begin tick; w++; end
      checks++;
      if (!ready) begin
        errors++; $display("FAIL b2b_wait_ready it=%0d got 0 exp 1 within 20 cycles", it);
        timed_out = 1'b1;
      end else begin
        for (int ch = 0; ch < 8; ch++) req[4*ch +: 4] = 4'($urandom_range(1, 15));
        exp_k = '0;
        for (int ch = 0; ch < 8; ch++) begin
          nib = req[4*ch +: 4];
          for (int b = 3; b >= 0; b--) if (nib[b]) exp_k[2*ch +: 2] = 2'(b);
        end
        hs_req = req; load = 1'b1;
        tick;
        load = 1'b0; hs_req = $urandom; dead_time = 4'($urandom_range(0, 15));
        b0 = distrip;
        tick; b1 = distrip;
        tick; b2 = distrip;
        dead_time = 4'd5;
        for (int ch = 0; ch < 8; ch++) got_k[2*ch +: 2] = {b1[ch], b2[ch]};
        checks++;
        if (b0 !== 8'hFF) begin errors++; $display("FAIL b2b_start it=%0d got %h exp ff", it, b0); end
        checks++;
        if (got_k !== exp_k) begin errors++; $display("FAIL b2b_decode it=%0d got %h exp %h", it, got_k, exp_k); end
      end
    end
    w = 0;
    while (!ready && w < 20) begin tick; w++; end
    checks++;
    if (overrun_cnt !== 16'd0 || sent_cnt !== 16'd800) begin
      errors++; $display("FAIL b2b_counters got ov=%0d s=%0d exp ov=0 s=800", overrun_cnt, sent_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_parallel;
    test_multihit;
    test_zero_load;
    test_overrun;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
